// File: rtl/mux_4_to_1_rr_arbiter.sv
// rtl/mux_4_to_1_rr_arbiter.sv - round-robin select controller for a 4-to-1 single-bit mux
// Optional macro ARB_HOLD_LIMIT_EN enables the HOLD_MAX forced-rotation limit.
module mux_4_to_1_rr_arbiter #(
  parameter int HOLD_MAX = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] i,
  output logic [1:0] sel,
  output logic [3:0] grant,
  output logic       gnt_valid,
  output logic       out
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] grant_q, grant_d;
  logic       gnt_valid_q, gnt_valid_d;
  logic [1:0] ptr_q, ptr_d;
`ifdef ARB_HOLD_LIMIT_EN
  logic [3:0] cnt_q, cnt_d;
`endif

  logic [2:0] any_win;
  logic [2:0] oth_win;
  logic       take;
  logic [1:0] take_idx;

  // Returns {found, index}: first set bit of r scanning start, start+1, ... mod 4.
  function automatic logic [2:0] rr_search(input logic [3:0] r, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int j = 3; j >= 0; j--) begin
      idx = start + 2'(j);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sel_q       <= 2'd0;
      grant_q     <= 4'b0000;
      gnt_valid_q <= 1'b0;
      ptr_q       <= 2'd0;
`ifdef ARB_HOLD_LIMIT_EN
      cnt_q       <= 4'd0;
`endif
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      grant_q     <= grant_d;
      gnt_valid_q <= gnt_valid_d;
      ptr_q       <= ptr_d;
`ifdef ARB_HOLD_LIMIT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    grant_d     = grant_q;
    gnt_valid_d = gnt_valid_q;
    ptr_d       = ptr_q;
`ifdef ARB_HOLD_LIMIT_EN
    cnt_d       = cnt_q;
`endif
    take        = 1'b0;
    take_idx    = 2'd0;
    any_win     = rr_search(req, ptr_q);
    // Handover search skips the current owner and starts just past it.
    oth_win     = rr_search(req & ~(4'b0001 << sel_q), sel_q + 2'd1);

    case (state_q)
      IDLE: begin
        if (any_win[2]) begin
          take     = 1'b1;
          take_idx = any_win[1:0];
        end
      end
      GRANT: begin
        if (!req[sel_q]) begin
          if (oth_win[2]) begin
            take     = 1'b1;
            take_idx = oth_win[1:0];
          end else begin
            state_d     = IDLE;
            grant_d     = 4'b0000;
            gnt_valid_d = 1'b0;
          end
`ifdef ARB_HOLD_LIMIT_EN
        end else if ((cnt_q == 4'(HOLD_MAX)) && oth_win[2]) begin
          take     = 1'b1;
          take_idx = oth_win[1:0];
        end else if (cnt_q != 4'(HOLD_MAX)) begin
          cnt_d = cnt_q + 4'd1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    if (take) begin
      state_d     = GRANT;
      sel_d       = take_idx;
      grant_d     = 4'b0001 << take_idx;
      gnt_valid_d = 1'b1;
      ptr_d       = take_idx + 2'd1;
`ifdef ARB_HOLD_LIMIT_EN
      cnt_d       = 4'd1;
`endif
    end
  end

  always_comb begin
    sel       = sel_q;
    grant     = grant_q;
    gnt_valid = gnt_valid_q;
    out       = gnt_valid_q & i[sel_q];
  end

endmodule

// File: tb/tb_mux_4_to_1_rr_arbiter.sv
// tb/tb_mux_4_to_1_rr_arbiter.sv - directed self-checking bench for mux_4_to_1_rr_arbiter
// Expectations adapt to whether ARB_HOLD_LIMIT_EN is defined (HOLD_MAX left at 4).
module tb_mux_4_to_1_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] i;
  logic [1:0] sel;
  logic [3:0] grant;
  logic       gnt_valid;
  logic       out;

  int tests = 0;
  int fails = 0;

`ifdef ARB_HOLD_LIMIT_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  mux_4_to_1_rr_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .i         (i),
    .sel       (sel),
    .grant     (grant),
    .gnt_valid (gnt_valid),
    .out       (out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    i   = 4'b0000;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 4'b1111;
    i   = 4'b1111;
    #2;
    tests++; if (grant !== 4'b0000) begin fails++; $display("FAIL reset_grant got=%b exp=0000", grant); end
    tests++; if (gnt_valid !== 1'b0) begin fails++; $display("FAIL reset_gv got=%b exp=0", gnt_valid); end
    tests++; if (sel !== 2'd0) begin fails++; $display("FAIL reset_sel got=%0d exp=0", sel); end
    tests++; if (out !== 1'b0) begin fails++; $display("FAIL reset_out got=%b exp=0", out); end
    step();
    rst = 1'b0;
    step();
    tests++; if (grant !== 4'b0001) begin fails++; $display("FAIL reset_first_grant got=%b exp=0001", grant); end
    step();
    #3;
    rst = 1'b1;
    #1;
    tests++; if (grant !== 4'b0000) begin fails++; $display("FAIL async_rst_grant got=%b exp=0000", grant); end
    tests++; if (gnt_valid !== 1'b0) begin fails++; $display("FAIL async_rst_gv got=%b exp=0", gnt_valid); end
    tests++; if (sel !== 2'd0) begin fails++; $display("FAIL async_rst_sel got=%0d exp=0", sel); end
    tests++; if (out !== 1'b0) begin fails++; $display("FAIL async_rst_out got=%b exp=0", out); end
    step();
    rst = 1'b0;
    step();
    tests++; if (grant !== 4'b0001) begin fails++; $display("FAIL rst_restart_grant got=%b exp=0001", grant); end
    tests++; if (sel !== 2'd0) begin fails++; $display("FAIL rst_restart_sel got=%0d exp=0", sel); end
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0100;
    i   = 4'b0100;
    step();
    tests++; if (grant !== 4'b0100) begin fails++; $display("FAIL single_grant got=%b exp=0100", grant); end
    tests++; if (sel !== 2'd2) begin fails++; $display("FAIL single_sel got=%0d exp=2", sel); end
    tests++; if (gnt_valid !== 1'b1) begin fails++; $display("FAIL single_gv got=%b exp=1", gnt_valid); end
    tests++; if (out !== 1'b1) begin fails++; $display("FAIL single_out got=%b exp=1", out); end
    i = 4'b1011;
    #1;
    tests++; if (out !== 1'b0) begin fails++; $display("FAIL single_out_comb got=%b exp=0", out); end
    i   = 4'b0100;
    req = 4'b0000;
    step();
    tests++; if (gnt_valid !== 1'b0) begin fails++; $display("FAIL single_drop_gv got=%b exp=0", gnt_valid); end
    tests++; if (out !== 1'b0) begin fails++; $display("FAIL single_drop_out got=%b exp=0", out); end
    tests++; if (grant !== 4'b0000) begin fails++; $display("FAIL single_drop_grant got=%b exp=0000", grant); end
    tests++; if (sel !== 2'd2) begin fails++; $display("FAIL single_drop_sel got=%0d exp=2", sel); end
  endtask

  task automatic test_round_robin();
    int exp_own;
    do_reset();
    req = 4'b1111;
    i   = 4'b1010;
    for (int t = 0; t < 20; t++) begin
      step();
      exp_own = HOLD_EN ? ((t / 4) % 4) : 0;
      tests++;
      if (sel !== 2'(exp_own) || grant !== (4'b0001 << exp_own) || out !== i[exp_own]) begin
        fails++;
        $display("FAIL rr_cycle%0d got sel=%0d grant=%b out=%b exp sel=%0d", t, sel, grant, out, exp_own);
      end
    end
    req = 4'b0000;
    step();
    tests++; if (gnt_valid !== 1'b0) begin fails++; $display("FAIL rr_end_gv got=%b exp=0", gnt_valid); end
  endtask

  task automatic test_release_handover();
    do_reset();
    req = 4'b0010;
    step();
    tests++; if (sel !== 2'd1) begin fails++; $display("FAIL ho_first_sel got=%0d exp=1", sel); end
    req = 4'b1011;
    step();
    tests++; if (sel !== 2'd1) begin fails++; $display("FAIL ho_hold_sel got=%0d exp=1", sel); end
    req = 4'b1001;
    step();
    tests++; if (sel !== 2'd3) begin fails++; $display("FAIL ho_new_sel got=%0d exp=3", sel); end
    tests++; if (grant !== 4'b1000) begin fails++; $display("FAIL ho_new_grant got=%b exp=1000", grant); end
    tests++; if (gnt_valid !== 1'b1) begin fails++; $display("FAIL ho_new_gv got=%b exp=1", gnt_valid); end
  endtask

  task automatic test_hold_saturation();
    do_reset();
    req = 4'b0100;
    for (int t = 0; t < 10; t++) begin
      step();
      tests++;
      if (grant !== 4'b0100) begin fails++; $display("FAIL sat_cycle%0d got=%b exp=0100", t, grant); end
    end
  endtask

  task automatic test_no_limit();
    int exp_own;
    do_reset();
    req = 4'b0011;
    for (int t = 0; t < 12; t++) begin
      step();
      exp_own = HOLD_EN ? ((t / 4) % 2) : 0;
      tests++;
      if (sel !== 2'(exp_own)) begin fails++; $display("FAIL pair_cycle%0d got=%0d exp=%0d", t, sel, exp_own); end
    end
    req = 4'b0010;
    step();
    tests++; if (sel !== 2'd1) begin fails++; $display("FAIL pair_drop_sel got=%0d exp=1", sel); end
    tests++; if (grant !== 4'b0010) begin fails++; $display("FAIL pair_drop_grant got=%b exp=0010", grant); end
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b0000;
    i   = 4'b0000;
    test_reset();
    test_single();
    test_round_robin();
    test_release_handover();
    test_hold_saturation();
    test_no_limit();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mux_4_to_1_rr_arbiter.md
# mux_4_to_1_rr_arbiter

Round-robin arbiter that shares the 4-to-1 single-bit mux datapath between four requesters. Each requester raises a request line; the block grants one at a time, drives the mux select, and presents the selected requester's data bit on a single output. It sits directly in front of the mux datapath as its select controller, with a hold limit that bounds how long one requester can keep the mux.

## Interface
- HOLD_MAX, 4: maximum consecutive grant cycles per owner while others wait; legal range 1..15.

- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req  input  4  request per requester; req[k] high = requester k wants the mux.
- i  input  4  data bits; i[k] belongs to requester k.
- sel  output  2  registered mux select = index of current owner.
- grant  output  4  registered one-hot grant; all zero when idle.
- gnt_valid  output  1  registered; high while any grant is active.
- out  output  1  i[sel] when gnt_valid, else 0 (combinational from registered sel).

## Operation
- States: IDLE, GRANT. Internal: ptr[1:0] (next search start), cnt[3:0] (hold count).
- Reset values: state IDLE, sel 0, grant 4'b0000, gnt_valid 0, out 0, ptr 0, cnt 0.
- Search: scan indices ptr, ptr+1, ptr+2, ptr+3 (mod 4); first with req set wins.
- IDLE: no req -> stay. Any req -> GRANT to search winner; grant one-hot of winner, sel = winner, cnt = 1, ptr = winner+1 mod 4.
- GRANT, owner k = sel:
  - req[k] low (release): search excluding k, starting at k+1. Winner found -> grant it directly (no idle cycle), cnt = 1. None -> IDLE, grant 0, gnt_valid 0, sel holds last value.
  - req[k] high, cnt == HOLD_MAX, some other req high: forced rotate to search winner excluding k starting at k+1; cnt = 1.
  - Otherwise stay; cnt increments, saturating at HOLD_MAX.
- Every new grant sets ptr = winner+1 mod 4.
- grant always equals one-hot of sel when gnt_valid; never more than one bit set.
- Requests are level-sensitive; a requester dropping req while not owner is simply skipped.

## Timing
- Grant latency: req rise at edge n -> grant/sel/gnt_valid valid after edge n+1.
- Handover (release or forced rotate): new owner valid on the edge following the condition; zero idle cycles.
- Hold: with all four requesting continuously, each owner holds exactly HOLD_MAX cycles, order 0,1,2,3,0...
- out follows i[sel] in the same cycle as i changes (no register in data path).
- rst asserted at any time, including mid-grant: all outputs go to reset values immediately, independent of clk; first grant after deassertion starts search at index 0.
- Simultaneous release by owner and new req from same index: release wins that edge; index re-arbitrated on the next search.

## Configuration
- ARB_HOLD_LIMIT_EN defined: hold limit and forced rotation active as described; cnt implemented.
- ARB_HOLD_LIMIT_EN undefined: no forced rotation; owner keeps grant until its req drops; cnt and HOLD_MAX unused (cnt removed). All other behaviour unchanged.

## Test plan
- Reset: rst=1 mid-grant with req=4'b1111 -> grant=0, gnt_valid=0, sel=0, out=0 immediately; after release, first grant goes to index 0.
- Single request: req=4'b0100, i=4'b0100 -> one cycle later grant=4'b0100, sel=2, out=1; drop req -> next cycle gnt_valid=0, out=0.
- Round robin with HOLD_MAX=4, macro defined, req=4'b1111 held 20 cycles -> owners 0,1,2,3,0 each for exactly 4 cycles, no gaps.
- Release handover: owner 1 drops req while req[3] and req[0] high -> next cycle sel=3 (search from 2), no idle cycle.
- Hold saturation: only req[2] high for 10 cycles, macro defined -> grant stays 4'b0100 throughout, no rotation.
- Macro undefined: req=4'b0011 for 12 cycles -> owner 0 held all 12 cycles; drop req[0] -> next cycle sel=1.
